// File: rtl/pipe_adder_if.sv
// Valid/ready handshake bundle for pipe_adder: operand side and result side.
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined ripple-segment adder: STAGES carry slices, one register per slice, full backpressure.
// The last slice register doubles as the output register.
module pipe_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic         clk,
  input logic         rstn,
  pipe_adder_if.slave bus
);
  localparam int unsigned Chunk = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_adder: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
  end

  logic [STAGES-1:0] valid;
  logic [STAGES:0]   adv;

  // A stage may load when it is empty or its successor is moving on.
  always_comb begin
    adv         = '0;
    adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !valid[k] || adv[k+1];
    end
  end

  assign bus.in_ready = rstn & adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = k * Chunk;
    localparam int unsigned Hi = Lo + Chunk;

    logic             v_in;
    logic             c_in;
    logic             v_q;
    logic             c_q;
    logic [Chunk-1:0] a_sl;
    logic [Chunk-1:0] b_sl;
    logic [Chunk:0]   slice;
    logic [Hi-1:0]    s_d;
    logic [Hi-1:0]    s_q;

    if (k == 0) begin : g_src
      assign v_in = bus.in_valid & bus.in_ready;
      assign c_in = bus.cin;
      assign a_sl = bus.a[Chunk-1:0];
      assign b_sl = bus.b[Chunk-1:0];
      assign s_d  = slice[Chunk-1:0];
    end else begin : g_src
      assign v_in = g_stage[k-1].v_q;
      assign c_in = g_stage[k-1].c_q;
      assign a_sl = g_stage[k-1].g_fwd.a_q[Chunk-1:0];
      assign b_sl = g_stage[k-1].g_fwd.b_q[Chunk-1:0];
      assign s_d  = {slice[Chunk-1:0], g_stage[k-1].s_q};
    end

    assign slice    = {1'b0, a_sl} + {1'b0, b_sl} + {{Chunk{1'b0}}, c_in};
    assign valid[k] = v_q;

    // Data registers only load on a valid slot so outputs hold their last value.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv[k]) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= slice[Chunk];
          s_q <= s_d;
        end
      end
    end

    // Skew registers carry the operand slices not yet consumed.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-Hi-1:0] a_d;
      logic [WIDTH-Hi-1:0] b_d;
      logic [WIDTH-Hi-1:0] a_q;
      logic [WIDTH-Hi-1:0] b_q;

      if (k == 0) begin : g_in
        assign a_d = bus.a[WIDTH-1:Hi];
        assign b_d = bus.b[WIDTH-1:Hi];
      end else begin : g_in
        assign a_d = g_stage[k-1].g_fwd.a_q[WIDTH-Lo-1:Chunk];
        assign b_d = g_stage[k-1].g_fwd.b_q[WIDTH-Lo-1:Chunk];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k] && v_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ovf_q <= 1'b0;
        end else if (adv[k] && v_in) begin
          ovf_q <= slice[Chunk] ^ (a_sl[Chunk-1] ^ b_sl[Chunk-1] ^ slice[Chunk-1]);
        end
      end
    end
  end

  assign bus.out_valid = valid[STAGES-1];
  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;

`ifdef FORMAL
  logic [WIDTH:0] ref_q [STAGES];
  int unsigned    since_rst_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      since_rst_q <= 0;
    end else if (since_rst_q < STAGES) begin
      since_rst_q <= since_rst_q + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv[0]) ref_q[0] <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) ref_q[k] <= ref_q[k-1];
    end
  end

  a_stall_hold: assert property (@(posedge clk) disable iff (!rstn)
    bus.out_valid && !bus.out_ready |=> $stable({bus.out_valid, bus.sum, bus.cout, bus.ovf}));
  a_no_early: assert property (@(posedge clk) disable iff (!rstn)
    since_rst_q < STAGES |-> !bus.out_valid);
  a_result: assert property (@(posedge clk) disable iff (!rstn)
    bus.out_valid |-> {bus.cout, bus.sum} == ref_q[STAGES-1]);
  c_cout: cover property (@(posedge clk) bus.out_valid && bus.cout);
  c_ovf: cover property (@(posedge clk) bus.out_valid && bus.ovf);
  c_full_stall: cover property (@(posedge clk) (&valid) && !bus.out_ready);
`endif
endmodule
